// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong engine.
//   - pong_state_e : FSM state encoding, also driven out on pong_core.state
//   - DEF_*        : default playfield geometry and timing
//   - clog2        : constant-function ceiling log2, never returns less than 1
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_e;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SIZE   = 10;
  localparam int DEF_PADDLE_W    = 10;
  localparam int DEF_PADDLE_H    = 60;
  localparam int DEF_BALL_SPEED  = 2;
  localparam int DEF_PADDLE_SPD  = 2;
  localparam int DEF_TICK_DIV    = 16;
  localparam int DEF_SERVE_TICKS = 32;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_WIN_SCORE   = 9;

  // Width needed to hold values 0..v-1; at least 1 so counters stay legal.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position register.
//   clk, rst : system clock, async active-high reset (paddle recentres)
//   tick     : movement enable pulse
//   en       : paddle may move in the current game state
//   up, dn   : move request; up wins when both are set
//   y        : paddle top edge, clamped to [0, SCREEN_H-PADDLE_H]
module pong_paddle #(
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE_SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);

  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] Y_RST = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] SPD   = 11'(PADDLE_SPEED);

  // 11-bit view so the saturation tests cannot wrap at 0 or 1023.
  logic [10:0] y_ext;
  assign y_ext = {1'b0, y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= 10'(Y_RST);
    end else if (tick && en) begin
      if (up)
        y <= (y_ext <= SPD) ? 10'd0 : 10'(y_ext - SPD);
      else if (dn)
        y <= (y_ext + SPD >= Y_MAX) ? 10'(Y_MAX) : 10'(y_ext + SPD);
    end
  end

endmodule

// File: rtl/pong_core.sv
// pong_core: two-player Pong engine (ball, paddles, scoring, game FSM).
//   clk, rst              : system clock, async active-high reset
//   p1_up/p1_dn           : player 1 buttons
//   p2_up/p2_dn           : player 2 buttons, ignored when p2_auto=1
//   p2_auto               : player 2 follows the ball
//   serve                 : start/restart request, level-sampled
//   ball_x/ball_y         : ball top-left corner
//   p1_y/p2_y             : paddle top edges
//   ball_dir_x/ball_dir_y : 1 = moving right/down
//   score_p1/score_p2     : scores
//   state                 : IDLE=0 SERVE=1 PLAY=2 OVER=3
//   point                 : one-cycle pulse alongside a score change
//   tick                  : one-cycle movement enable
// All motion is gated by the registered tick, so every position/score
// update lands the cycle after tick=1.
module pong_core
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPD,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int SERVE_TICKS  = DEF_SERVE_TICKS,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic               p2_auto,
  input  logic               serve,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         p1_y,
  output logic [9:0]         p2_y,
  output logic               ball_dir_x,
  output logic               ball_dir_y,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         state,
  output logic               point,
  output logic               tick
);

  localparam int SC_W = clog2(SERVE_TICKS + 1);

  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] SH   = 11'(SCREEN_H);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] PW   = 11'(PADDLE_W);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] BSPD = 11'(BALL_SPEED);
  localparam logic [9:0]  CX   = 10'(SCREEN_W / 2);
  localparam logic [9:0]  CY   = 10'(SCREEN_H / 2);

  localparam logic [TICK_DIV-1:0] TICK_PRE  = TICK_DIV'((1 << TICK_DIV) - 2);
  localparam logic [SC_W-1:0]     SERVE_LD  = SC_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0]  WIN       = SCORE_W'(WIN_SCORE);

  pong_state_e         st;
  logic [TICK_DIV-1:0] tick_cnt;
  logic [SC_W-1:0]     serve_cnt;

  assign state = st;

  // Tick is registered: it is raised while the counter sits at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= (tick_cnt == TICK_PRE);
    end
  end

  // ---------------------------------------------------------------------
  // Next ball position for a PLAY tick. Uses pre-tick paddle positions.
  // ---------------------------------------------------------------------
  logic [10:0] bx, by, p1e, p2e;
  logic [9:0]  nx, ny;
  logic        ndx, ndy, miss_l, miss_r;

  assign bx  = {1'b0, ball_x};
  assign by  = {1'b0, ball_y};
  assign p1e = {1'b0, p1_y};
  assign p2e = {1'b0, p2_y};

  always_comb begin
    ny     = ball_y;
    ndy    = ball_dir_y;
    nx     = ball_x;
    ndx    = ball_dir_x;
    miss_l = 1'b0;
    miss_r = 1'b0;

    if (ball_dir_y) begin
      if (by + BS + BSPD >= SH) begin
        ny  = 10'(SH - BS);
        ndy = 1'b0;
      end else begin
        ny = 10'(by + BSPD);
      end
    end else begin
      if (by <= BSPD) begin
        ny  = 10'd0;
        ndy = 1'b1;
      end else begin
        ny = 10'(by - BSPD);
      end
    end

    if (!ball_dir_x) begin
      if (bx <= PW + BSPD) begin
        if (by + BS > p1e && by < p1e + PH) begin
          nx  = 10'(PW);
          ndx = 1'b1;
        end else begin
          miss_l = 1'b1;
        end
      end else begin
        nx = 10'(bx - BSPD);
      end
    end else begin
      if (bx + BS + BSPD >= SW - PW) begin
        if (by + BS > p2e && by < p2e + PH) begin
          nx  = 10'(SW - PW - BS);
          ndx = 1'b0;
        end else begin
          miss_r = 1'b1;
        end
      end else begin
        nx = 10'(bx + BSPD);
      end
    end
  end

  logic [SCORE_W-1:0] s1_inc, s2_inc;
  assign s1_inc = score_p1 + 1'b1;
  assign s2_inc = score_p2 + 1'b1;

  // ---------------------------------------------------------------------
  // Game FSM, ball and score registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      serve_cnt  <= '0;
      ball_x     <= CX;
      ball_y     <= CY;
      ball_dir_x <= 1'b1;
      ball_dir_y <= 1'b1;
      score_p1   <= '0;
      score_p2   <= '0;
      point      <= 1'b0;
    end else begin
      point <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (serve) begin
            st        <= ST_SERVE;
            serve_cnt <= SERVE_LD;
          end
        end
        ST_SERVE: begin
          ball_x <= CX;
          ball_y <= CY;
          if (tick) begin
            // <=1 also covers a zero-length serve instead of underflowing
            if (serve_cnt <= SC_W'(1)) begin
              serve_cnt <= '0;
              st        <= ST_PLAY;
            end else begin
              serve_cnt <= serve_cnt - 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            ball_y     <= ny;
            ball_dir_y <= ndy;
            if (miss_l) begin
              // P1 missed: P2 scores, ball recentres heading toward P2
              score_p2   <= s2_inc;
              point      <= 1'b1;
              ball_x     <= CX;
              ball_y     <= CY;
              ball_dir_x <= 1'b1;
              serve_cnt  <= SERVE_LD;
              st         <= (s2_inc == WIN) ? ST_OVER : ST_SERVE;
            end else if (miss_r) begin
              score_p1   <= s1_inc;
              point      <= 1'b1;
              ball_x     <= CX;
              ball_y     <= CY;
              ball_dir_x <= 1'b0;
              serve_cnt  <= SERVE_LD;
              st         <= (s1_inc == WIN) ? ST_OVER : ST_SERVE;
            end else begin
              ball_x     <= nx;
              ball_dir_x <= ndx;
            end
          end
        end
        ST_OVER: begin
          ball_x <= CX;
          ball_y <= CY;
          if (serve) begin
            score_p1  <= '0;
            score_p2  <= '0;
            serve_cnt <= SERVE_LD;
            st        <= ST_SERVE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Paddles
  // ---------------------------------------------------------------------
  logic        pad_en;
  logic [10:0] ball_c, p2_c;
  logic        p2_up_req, p2_dn_req;

  assign pad_en = (st == ST_SERVE) || (st == ST_PLAY);

  // Auto mode compares centres; equal centres hold still.
  assign ball_c    = by + 11'(BALL_SIZE / 2);
  assign p2_c      = p2e + 11'(PADDLE_H / 2);
  assign p2_up_req = p2_auto ? (ball_c < p2_c) : p2_up;
  assign p2_dn_req = p2_auto ? (ball_c > p2_c) : p2_dn;

  pong_paddle #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED)
  ) u_pad1 (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .en  (pad_en),
    .up  (p1_up),
    .dn  (p1_dn),
    .y   (p1_y)
  );

  pong_paddle #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED)
  ) u_pad2 (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .en  (pad_en),
    .up  (p2_up_req),
    .dn  (p2_dn_req),
    .y   (p2_y)
  );

endmodule

// File: doc/pong_core.md
# pong_core

Parametrised two-player Pong engine: ball motion, two paddles (player 2 optionally computer-driven), wall/paddle collision, scoring and a serve/play/game-over state machine. It runs from the system clock with an internal tick enable and uses no derived clocks. It sits between the input pins and the video/score renderer, which consume its registered position and score outputs.

## Interface
- `SCREEN_W`, 640, playfield width in pixels
- `SCREEN_H`, 480, playfield height in pixels
- `BALL_SIZE`, 10, ball edge length; the ball is a square and (`ball_x`, `ball_y`) is its top-left corner
- `PADDLE_W`, 10, paddle width; P1 occupies x∈[0,PADDLE_W), P2 occupies x∈[SCREEN_W−PADDLE_W,SCREEN_W)
- `PADDLE_H`, 60, paddle height
- `BALL_SPEED`, 2, ball pixels per tick per axis
- `PADDLE_SPEED`, 2, paddle pixels per tick
- `TICK_DIV`, 16, tick counter width; one tick every 2^TICK_DIV clocks
- `SERVE_TICKS`, 32, ticks the ball is held at centre before play
- `SCORE_W`, 4, score counter width
- `WIN_SCORE`, 9, points that end the game; must be < 2^SCORE_W
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `p1_up`, `p1_dn`  in  1 each  P1 buttons
- `p2_up`, `p2_dn`  in  1 each  P2 buttons; ignored when `p2_auto`=1
- `p2_auto`  in  1  P2 tracks the ball automatically
- `serve`  in  1  start or restart request, level-sampled
- `ball_x`, `ball_y`  out  10 each  ball position
- `p1_y`, `p2_y`  out  10 each  paddle top edges
- `ball_dir_x`, `ball_dir_y`  out  1 each  1 = right/down
- `score_p1`, `score_p2`  out  SCORE_W each  scores
- `state`  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
- `point`  out  1  one-cycle pulse when a point is scored
- `tick`  out  1  one-cycle movement enable

## Operation
- **Tick:** `tick`=1 in the cycle the tick counter equals all-ones; the counter then wraps. All motion happens only on tick cycles.
- **IDLE:** `serve`=1 → SERVE; the serve counter is loaded with SERVE_TICKS.
- **SERVE:**
  - Ball is held at centre (SCREEN_W/2, SCREEN_H/2).
  - Paddles move.
  - Each tick decrements the serve counter; the tick on which it reaches 0 → PLAY.
- **PLAY, per tick:**
  - Y axis: moving down and ball_y+BALL_SIZE+BALL_SPEED ≥ SCREEN_H → ball_y=SCREEN_H−BALL_SIZE, dir_y=0.
  - Y axis: moving up and ball_y ≤ BALL_SPEED → ball_y=0, dir_y=1.
  - Y axis otherwise: ±BALL_SPEED.
  - X axis, moving left with ball_x ≤ PADDLE_W+BALL_SPEED:
    - Hit when ball_y+BALL_SIZE > p1_y and ball_y < p1_y+PADDLE_H → ball_x=PADDLE_W, dir_x=1.
    - Otherwise a miss: point to P2.
  - X axis, moving right with ball_x+BALL_SIZE+BALL_SPEED ≥ SCREEN_W−PADDLE_W:
    - Hit test is the same against p2_y → ball_x=SCREEN_W−PADDLE_W−BALL_SIZE, dir_x=0.
    - Otherwise a miss: point to P1.
  - X axis otherwise: ±BALL_SPEED.
  - X and Y events in the same tick are both applied, so corner bounces are legal.
  - Hit tests use paddle positions from before this tick's paddle update.
- **Point:**
  - Winner's score increments and `point` pulses.
  - Ball recentres; dir_x points toward the scorer, so the next serve goes to the loser; dir_y is kept.
  - Winner's new score = WIN_SCORE → OVER; otherwise → SERVE with the serve counter reloaded.
- **OVER:**
  - Ball is frozen at centre and scores are held.
  - `serve`=1 → clear both scores, reload the serve counter, → SERVE.
- **Paddles:**
  - Move on every tick in every state except IDLE and OVER.
  - Up has priority over down.
  - Up: p_y = max(0, p_y−PADDLE_SPEED). Down: p_y = min(SCREEN_H−PADDLE_H, p_y+PADDLE_SPEED). Neither pressed: hold.
  - Auto mode: up if the ball centre is above the paddle centre, down if below, hold if equal.
- **Arithmetic:** comparisons use 11-bit unsigned intermediates, so there is no wrap-around at 0 or 1023.

## Timing
- **Reset values:**
  - ball = (SCREEN_W/2, SCREEN_H/2); dir_x = dir_y = 1.
  - p1_y = p2_y = (SCREEN_H−PADDLE_H)/2.
  - Scores 0; state IDLE; `point`=0; `tick`=0; tick counter 0.
- All outputs are registered. Position, score and state updates appear the cycle after the `tick`=1 cycle (1-cycle latency).
- `point` is asserted in the same cycle the score output changes.
- `serve` is sampled every cycle in IDLE/OVER and needs no tick; the transition appears on the next clock.
- `rst` mid-game returns every register to its reset value immediately, independent of `clk`.

## Structure
- `pong_pkg`:
  - state encoding localparams (IDLE, SERVE, PLAY, OVER);
  - default geometry constants;
  - the `clog2` helper.
- Sub-module `pong_paddle`, instantiated twice:
  - parameters: SCREEN_H, PADDLE_H, PADDLE_SPEED;
  - ports: clk, rst, tick, en, up, dn, y.
  - The auto-tracking request logic lives in `pong_core` and drives P2's up/dn.

## Test plan
Run with TICK_DIV=2 and SERVE_TICKS=2.
1. Reset then `serve` pulse → state SERVE; PLAY after 2 ticks; on the first PLAY tick ball = (322,242).
2. Ball (200,468) moving down-right → next tick ball_y=470, dir_y=0; the following tick ball_y=468.
3. Ball (12,230) moving left with p1_y=210 → hit: ball_x=10, dir_x=1, no `point`.
4. Same as 3 with p1_y=0 → `point` pulses, score_p2=1, ball=(320,240), dir_x=1, state SERVE.
5. score_p1=8, then P2 misses → score_p1=9, state OVER; `serve` → both scores 0, state SERVE.
6. p1_up held with p1_y=1 → p1_y=0 and stays there; p2_auto=1 with ball centre below the paddle centre → p2_y increases 2 per tick, saturating at 420.
